d_mem_arbiter: RTL and testbench

//  - Shares the single-port data memory (d_mem) between two requesters: port 0 = CPU load/store, port 1 = debug/DMA loader.
//  - Round-robin arbitration, req/ack handshake, one memory access per transaction, registered read data.
//  - Sits between the requesters and d_mem; owns d_mem's address/writeData/memWrite/memRead and consumes its readData.

---
 rtl/d_mem_arb_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 14 +
 rtl/d_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_d_mem_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/d_mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package d_mem_arb_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // Request payload captured from the winning port
    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: on contention the port that did not win last time is chosen.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt,
    output logic       any
);

    always_comb begin
        any = |req;
        gnt = (req == 2'b11) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/d_mem_arbiter.sv
// Shares single-port d_mem between CPU (port 0) and debug/DMA loader (port 1).
// Optional address bounds check enabled by D_MEM_ARBITER_BOUNDS_CHECK_EN.
module d_mem_arbiter
    import d_mem_arb_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [WORD_W-1:0] addr0,
    input  logic [WORD_W-1:0] addr1,
    input  logic [WORD_W-1:0] wdata0,
    input  logic [WORD_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [WORD_W-1:0] rdata0,
    output logic [WORD_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [WORD_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_writeData,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [WORD_W-1:0] mem_readData
);

`ifdef D_MEM_ARBITER_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_t   state;
    logic     last_grant;
    logic     gnt_q;
    logic     we_q;
    logic     oob_q;

    logic     gnt_c;
    logic     any_c;
    logic     oob_c;
    mem_req_t sel_c;

    rr_arbiter2 u_rr (
        .req        ({req1, req0}),
        .last_grant (last_grant),
        .gnt        (gnt_c),
        .any        (any_c)
    );

    // Winner's payload and its range check; with the check disabled oob_c folds to 0
    always_comb begin
        sel_c = (gnt_c == PORT_AUX) ? {we1, addr1, wdata1} : {we0, addr0, wdata0};
        oob_c = BOUNDS_EN && (sel_c.addr >= WORD_W'(MEM_SIZE));
    end

    // IDLE -> ACCESS -> RESP; memory strobes are only ever high in ACCESS
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            last_grant    <= PORT_AUX;
            gnt_q         <= PORT_CPU;
            we_q          <= 1'b0;
            oob_q         <= 1'b0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            err0          <= 1'b0;
            err1          <= 1'b0;
            rdata0        <= '0;
            rdata1        <= '0;
            mem_address   <= '0;
            mem_writeData <= '0;
            mem_memWrite  <= 1'b0;
            mem_memRead   <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_c) begin
                        gnt_q         <= gnt_c;
                        last_grant    <= gnt_c;
                        we_q          <= sel_c.we;
                        oob_q         <= oob_c;
                        mem_address   <= sel_c.addr;
                        mem_writeData <= sel_c.wdata;
                        mem_memWrite  <= sel_c.we & ~oob_c;
                        mem_memRead   <= ~sel_c.we & ~oob_c;
                        state         <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!we_q) begin
                        if (gnt_q == PORT_AUX) rdata1 <= oob_q ? '0 : mem_readData;
                        else                   rdata0 <= oob_q ? '0 : mem_readData;
                    end
                    ack0          <= (gnt_q == PORT_CPU);
                    ack1          <= (gnt_q == PORT_AUX);
                    err0          <= oob_q && (gnt_q == PORT_CPU);
                    err1          <= oob_q && (gnt_q == PORT_AUX);
                    mem_address   <= '0;
                    mem_writeData <= '0;
                    mem_memWrite  <= 1'b0;
                    mem_memRead   <= 1'b0;
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    mem_address   <= '0;
                    mem_writeData <= '0;
                    mem_memWrite  <= 1'b0;
                    mem_memRead   <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Directed bench for d_mem_arbiter with a small 8-byte d_mem model.
// Expectations for the out-of-range read follow D_MEM_ARBITER_BOUNDS_CHECK_EN.
module tb_d_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_address, mem_writeData, mem_readData;
    logic        mem_memWrite, mem_memRead;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] dmem [0:1] = '{32'h0, 32'h0};

    d_mem_arbiter #(.MEM_SIZE(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .req0          (req0),
        .req1          (req1),
        .we0           (we0),
        .we1           (we1),
        .addr0         (addr0),
        .addr1         (addr1),
        .wdata0        (wdata0),
        .wdata1        (wdata1),
        .ack0          (ack0),
        .ack1          (ack1),
        .rdata0        (rdata0),
        .rdata1        (rdata1),
        .err0          (err0),
        .err1          (err1),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_memWrite  (mem_memWrite),
        .mem_memRead   (mem_memRead),
        .mem_readData  (mem_readData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word-addressed memory: addr[1:0] ignored, addr[2] selects one of two words
    always @(posedge clock) begin
        if (mem_memWrite) dmem[mem_address[2]] <= mem_writeData;
    end
    assign mem_readData = dmem[mem_address[2]];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] oob_rd_strobe;
        logic [31:0] oob_err;
        logic [31:0] oob_rdata;
`ifdef D_MEM_ARBITER_BOUNDS_CHECK_EN
        oob_rd_strobe = 32'd0;
        oob_err       = 32'd1;
        oob_rdata     = 32'h0;
`else
        oob_rd_strobe = 32'd1;
        oob_err       = 32'd0;
        oob_rdata     = 32'h1234_5678;
`endif
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick; tick;
        chk("rst_ack0", 32'(ack0), 32'd0);
        chk("rst_ack1", 32'(ack1), 32'd0);
        chk("rst_err", 32'({err0, err1}), 32'd0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_mem", 32'({mem_memWrite, mem_memRead}), 32'd0);
        chk("rst_maddr", mem_address, 32'h0);
        reset = 1'b0;
        tick;

        // Port 0 write addr 4
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd4; wdata0 = 32'hDEAD_BEEF;
        tick;
        chk("wr_memWrite", 32'(mem_memWrite), 32'd1);
        chk("wr_memRead", 32'(mem_memRead), 32'd0);
        chk("wr_maddr", mem_address, 32'd4);
        chk("wr_mwdata", mem_writeData, 32'hDEAD_BEEF);
        chk("wr_ack_early", 32'(ack0), 32'd0);
        tick;
        chk("wr_ack0", 32'(ack0), 32'd1);
        chk("wr_err0", 32'(err0), 32'd0);
        chk("wr_strobe_off", 32'(mem_memWrite), 32'd0);
        req0 = 1'b0;
        tick;
        chk("wr_ack_drop", 32'(ack0), 32'd0);

        // Port 0 read addr 4
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd4;
        tick;
        chk("rd_memRead", 32'(mem_memRead), 32'd1);
        chk("rd_memWrite", 32'(mem_memWrite), 32'd0);
        tick;
        chk("rd_ack0", 32'(ack0), 32'd1);
        chk("rd_rdata0", rdata0, 32'hDEAD_BEEF);
        chk("rd_strobe_off", 32'(mem_memRead), 32'd0);
        req0 = 1'b0;
        tick;
        chk("rd_ack_drop", 32'(ack0), 32'd0);
        chk("rd_hold", rdata0, 32'hDEAD_BEEF);

        // Fairness: both ports held after reset -> acks 0,1,0,1 at ticks 2,5,8,11
        reset = 1'b1;
        tick;
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
        for (int k = 1; k <= 12; k++) begin
            tick;
            chk($sformatf("fair_ack0_t%0d", k), 32'(ack0), 32'((k == 2) || (k == 8)));
            chk($sformatf("fair_ack1_t%0d", k), 32'(ack1), 32'((k == 5) || (k == 11)));
            if (k == 5) chk("fair_rdata1", rdata1, 32'hDEAD_BEEF);
        end
        chk("fair_rdata0", rdata0, 32'h0);
        req0 = 1'b0; req1 = 1'b0;
        tick; tick; tick;

        // Reset during ACCESS of a port-1 read
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
        tick;
        chk("abort_memRead", 32'(mem_memRead), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_memRead_off", 32'(mem_memRead), 32'd0);
        chk("abort_maddr", mem_address, 32'h0);
        chk("abort_rdata1", rdata1, 32'h0);
        req1 = 1'b0;
        tick;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk($sformatf("abort_no_ack1_%0d", k), 32'(ack1), 32'd0);
        end
        req1 = 1'b1;
        tick; tick;
        chk("fresh_ack1", 32'(ack1), 32'd1);
        chk("fresh_rdata1", rdata1, 32'hDEAD_BEEF);
        req1 = 1'b0;
        tick;

        // Word 0 = 0x12345678, then reload rdata0 from addr 4
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd0; wdata0 = 32'h1234_5678;
        tick; tick;
        chk("w0_ack0", 32'(ack0), 32'd1);
        req0 = 1'b0;
        tick;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd4;
        tick; tick;
        chk("r4_rdata0", rdata0, 32'hDEAD_BEEF);
        req0 = 1'b0;
        tick;

        // Boundary: read addr 8 with MEM_SIZE 8
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8;
        tick;
        chk("oob_memRead", 32'(mem_memRead), oob_rd_strobe);
        chk("oob_memWrite", 32'(mem_memWrite), 32'd0);
        tick;
        chk("oob_ack0", 32'(ack0), 32'd1);
        chk("oob_err0", 32'(err0), oob_err);
        chk("oob_rdata0", rdata0, oob_rdata);
        chk("oob_strobe_off", 32'({mem_memWrite, mem_memRead}), 32'd0);
        req0 = 1'b0;
        tick;
        chk("oob_ack_drop", 32'(ack0), 32'd0);
        chk("oob_err_drop", 32'(err0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
